mul_issue_ctrl: RTL and testbench

Issue/retire controller for the multiplier in the execute stage. Accepts a multiply from the pipeline, registers operands and pulses the multiplier start, and holds operands stable while the multiplier runs. It stalls the pipeline until completion, then applies signed fix-up and delivers the 64-bit product as HI/LO. It sits directly upstream and downstream of `multiplier`: it drives the multiplier's `mul`, `a` and `b` inputs and consumes its `done` and `result` outputs.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_issue_ctrl_if.sv | 29 ++
 rtl/mul_sign_fix.sv | 23 ++
 rtl/mul_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier issue/retire controller.
package mul_pkg;

    localparam int XLEN   = 32;
    localparam int PROD_W = 2 * XLEN;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } state_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Pipeline and multiplier handshake bundle; slave is the controller, master is its environment.
interface mul_issue_ctrl_if;

    logic                          issue_valid;
    logic                          issue_signed;
    logic [0:mul_pkg::XLEN-1]      op_a;
    logic [0:mul_pkg::XLEN-1]      op_b;
    logic                          flush;
    logic                          stall;
    logic                          mul_start;
    logic [0:mul_pkg::XLEN-1]      mul_a;
    logic [0:mul_pkg::XLEN-1]      mul_b;
    logic                          mul_done;
    logic [0:mul_pkg::PROD_W-1]    mul_result;
    logic                          res_valid;
    logic [0:mul_pkg::XLEN-1]      res_hi;
    logic [0:mul_pkg::XLEN-1]      res_lo;

    modport master (
        output issue_valid, issue_signed, op_a, op_b, flush, mul_done, mul_result,
        input  stall, mul_start, mul_a, mul_b, res_valid, res_hi, res_lo
    );

    modport slave (
        input  issue_valid, issue_signed, op_a, op_b, flush, mul_done, mul_result,
        output stall, mul_start, mul_a, mul_b, res_valid, res_hi, res_lo
    );

endinterface

// File: rtl/mul_sign_fix.sv
// Combinational operand magnitude and conditional product negate for the signed multiply path.
module mul_sign_fix
    import mul_pkg::*;
(
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              is_signed,
    input  logic              negate,
    input  logic [PROD_W-1:0] prod_in,
    output logic [XLEN-1:0]   abs_a,
    output logic [XLEN-1:0]   abs_b,
    output logic [PROD_W-1:0] prod_out
);

    localparam logic [XLEN-1:0]   ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [PROD_W-1:0] ONE_P = {{(PROD_W-1){1'b0}}, 1'b1};

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign abs_a    = (is_signed && op_a[XLEN-1]) ? (~op_a + ONE_X) : op_a;
    assign abs_b    = (is_signed && op_b[XLEN-1]) ? (~op_b + ONE_X) : op_b;
    assign prod_out = negate ? (~prod_in + ONE_P) : prod_in;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiplier issue/retire controller: issues operand magnitudes, waits for done, fixes sign, retires HI/LO.
// Build option: define MUL_SIGNED_EN to enable the signed multiply path.
module mul_issue_ctrl
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mul_issue_ctrl_if.slave  bus
);

    state_t              state_r;
    logic                neg_r;
    logic                mul_start_r;
    logic                res_valid_r;
    logic [XLEN-1:0]     mul_a_r;
    logic [XLEN-1:0]     mul_b_r;
    logic [XLEN-1:0]     res_hi_r;
    logic [XLEN-1:0]     res_lo_r;
    logic [PROD_W-1:0]   prod_r;

    logic [XLEN-1:0]     op_a_s;
    logic [XLEN-1:0]     op_b_s;
    logic [PROD_W-1:0]   mul_result_s;
    logic [XLEN-1:0]     abs_a_s;
    logic [XLEN-1:0]     abs_b_s;
    logic                neg_s;
    logic [PROD_W-1:0]   fixed_s;
    logic                stall_s;

    // Bus vectors number bit 0 as MSB; whole-vector copies keep the numeric value.
    assign op_a_s       = bus.op_a;
    assign op_b_s       = bus.op_b;
    assign mul_result_s = bus.mul_result;

`ifdef MUL_SIGNED_EN
    mul_sign_fix u_sign_fix (
        .op_a      (op_a_s),
        .op_b      (op_b_s),
        .is_signed (bus.issue_signed),
        .negate    (neg_r),
        .prod_in   (prod_r),
        .abs_a     (abs_a_s),
        .abs_b     (abs_b_s),
        .prod_out  (fixed_s)
    );
    assign neg_s = bus.issue_signed & (op_a_s[XLEN-1] ^ op_b_s[XLEN-1]);
`else
    logic unused_sign_s;
    assign unused_sign_s = bus.issue_signed ^ neg_r;
    assign abs_a_s       = op_a_s;
    assign abs_b_s       = op_b_s;
    assign neg_s         = 1'b0;
    assign fixed_s       = prod_r;
`endif

    // Pipeline freeze: only DONE releases an in-flight instruction; IDLE/DRAIN follow issue_valid.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = bus.issue_valid;
            START:   stall_s = 1'b1;
            WAIT:    stall_s = 1'b1;
            FIX:     stall_s = 1'b1;
            DONE:    stall_s = 1'b0;
            DRAIN:   stall_s = bus.issue_valid;
            default: stall_s = 1'b0;
        endcase
    end

    // Issue/retire sequencer with registered multiplier and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            neg_r       <= 1'b0;
            mul_start_r <= 1'b0;
            res_valid_r <= 1'b0;
            mul_a_r     <= {XLEN{1'b0}};
            mul_b_r     <= {XLEN{1'b0}};
            res_hi_r    <= {XLEN{1'b0}};
            res_lo_r    <= {XLEN{1'b0}};
            prod_r      <= {PROD_W{1'b0}};
        end else begin
            mul_start_r <= 1'b0;
            res_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.issue_valid && !bus.flush) begin
                        mul_a_r     <= abs_a_s;
                        mul_b_r     <= abs_b_s;
                        neg_r       <= neg_s;
                        mul_start_r <= 1'b1;
                        state_r     <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    state_r <= bus.flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    // A flush coinciding with done has nothing left to drain.
                    if (bus.flush) begin
                        state_r <= bus.mul_done ? IDLE : DRAIN;
                    end else if (bus.mul_done) begin
                        prod_r  <= mul_result_s;
                        state_r <= FIX;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state_r <= IDLE;
                    end else begin
                        res_hi_r    <= fixed_s[PROD_W-1:XLEN];
                        res_lo_r    <= fixed_s[XLEN-1:0];
                        res_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                DRAIN: begin
                    state_r <= bus.mul_done ? IDLE : DRAIN;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall     = stall_s;
    assign bus.mul_start = mul_start_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_hi    = res_hi_r;
    assign bus.res_lo    = res_lo_r;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a behavioural 4-cycle multiplier and a product reference model.
module tb_mul_issue_ctrl;

`ifdef MUL_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mul_issue_ctrl_if bus ();

    mul_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: captures operands on mul, raises done for one cycle four cycles later.
    logic [63:0] mdl_a;
    logic [63:0] mdl_b;
    int          mdl_cnt;
    always @(posedge clk) begin
        if (reset) begin
            mdl_cnt        <= 0;
            bus.mul_done   <= 1'b0;
            bus.mul_result <= 64'd0;
        end else begin
            bus.mul_done <= 1'b0;
            if (bus.mul_start) begin
                mdl_a   <= {32'd0, bus.mul_a};
                mdl_b   <= {32'd0, bus.mul_b};
                mdl_cnt <= 3;
            end else if (mdl_cnt != 0) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1) begin
                    bus.mul_done   <= 1'b1;
                    bus.mul_result <= mdl_a * mdl_b;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        if (sgn && SIGNED_BUILD) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // One full transaction from acceptance (cycle 0) to retirement, with cycle-exact handshake checks.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
        logic [63:0] exp;
        logic [8:0]  stall_h;
        logic [8:0]  start_h;
        logic [8:0]  valid_h;
        exp     = ref_prod(a, b, sgn);
        stall_h = 9'd0;
        start_h = 9'd0;
        valid_h = 9'd0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.issue_valid  = 1'b1;
                bus.issue_signed = sgn;
                bus.op_a         = a;
                bus.op_b         = b;
            end
            if (c == 8) bus.issue_valid = 1'b0;
            #1;
            stall_h[c] = bus.stall;
            start_h[c] = bus.mul_start;
            valid_h[c] = bus.res_valid;
            if (c == 7) check_eq({tag, "_prod"}, {bus.res_hi, bus.res_lo}, exp);
        end
        check_eq({tag, "_stall"}, {55'd0, stall_h}, 64'h7F);
        check_eq({tag, "_start"}, {55'd0, start_h}, 64'h2);
        check_eq({tag, "_valid"}, {55'd0, valid_h}, 64'h80);
    endtask

    logic [31:0] corner [0:5];
    logic [63:0] prior;
    logic [63:0] exp_b;
    int          valid_cnt;
    int          valid_at;
    int          start_cnt;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        checks = 0;
        errors = 0;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        corner[4] = 32'h0000_0001;
        corner[5] = 32'h8000_0001;
        reset            = 1'b1;
        bus.issue_valid  = 1'b0;
        bus.issue_signed = 1'b0;
        bus.op_a         = 32'd0;
        bus.op_b         = 32'd0;
        bus.flush        = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_stall", {63'd0, bus.stall}, 64'd0);
        check_eq("rst_start", {63'd0, bus.mul_start}, 64'd0);
        check_eq("rst_valid", {63'd0, bus.res_valid}, 64'd0);
        check_eq("rst_ab", {bus.mul_a, bus.mul_b}, 64'd0);
        check_eq("rst_res", {bus.res_hi, bus.res_lo}, 64'd0);

        run_op(32'h0000_FFFF, 32'h0001_0000, 1'b0, "unsigned");
        run_op(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, "neg1x3");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "minxmin");
        run_op(32'h0000_0000, 32'h8000_0001, 1'b1, "zero");
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, "m1x2");

        // Flush at cycle 3, second instruction waiting from cycle 4.
        prior     = {bus.res_hi, bus.res_lo};
        exp_b     = ref_prod(32'hFFFF_FFF9, 32'h0000_0005, 1'b1);
        valid_cnt = 0;
        valid_at  = -1;
        start_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            case (c)
                0: begin
                    bus.issue_valid = 1'b1; bus.issue_signed = 1'b0;
                    bus.op_a = 32'h1234_5678; bus.op_b = 32'h9ABC_DEF0;
                end
                3: bus.flush = 1'b1;
                4: begin
                    bus.flush = 1'b0; bus.issue_signed = 1'b1;
                    bus.op_a = 32'hFFFF_FFF9; bus.op_b = 32'h0000_0005;
                end
                14: bus.issue_valid = 1'b0;
                default: ;
            endcase
            #1;
            if (bus.res_valid) begin
                valid_cnt++;
                valid_at = c;
            end
            if (bus.mul_start) start_cnt++;
            if (c == 12) check_eq("flush_hold", {bus.res_hi, bus.res_lo}, prior);
            if (c == 13) check_eq("flush_next", {bus.res_hi, bus.res_lo}, exp_b);
        end
        check_eq("flush_vcnt", 64'(valid_cnt), 64'd1);
        check_eq("flush_vat", 64'(valid_at), 64'd13);
        check_eq("flush_starts", 64'(start_cnt), 64'd2);

        // Reset in the middle of a multiply.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.issue_valid = 1'b1; bus.issue_signed = 1'b1;
                bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1357_9BDF;
            end
            if (c == 4) begin
                reset = 1'b1;
                bus.issue_valid = 1'b0;
            end
            if (c == 5) reset = 1'b0;
        end
        #1;
        check_eq("mrst_stall", {63'd0, bus.stall}, 64'd0);
        check_eq("mrst_start", {63'd0, bus.mul_start}, 64'd0);
        check_eq("mrst_valid", {63'd0, bus.res_valid}, 64'd0);
        check_eq("mrst_ab", {bus.mul_a, bus.mul_b}, 64'd0);
        check_eq("mrst_res", {bus.res_hi, bus.res_lo}, 64'd0);
        run_op(32'd7, 32'd6, 1'b0, "after_rst");

        for (int i = 0; i < 16; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
